uart_irq_ctrl: RTL and testbench
================================

# uart_irq_ctrl

Parametrised interrupt controller for the UART core: captures per-source events into sticky pending bits (level or rising-edge per source), applies a mask, and drives a per-source IRQ bus plus one combined, coalesced interrupt line with a lowest-index source ID. It sits between the UART event sources (TX/RX FIFO, line-error and timeout logic) and the register file, which drives the enable, mask, set and clear vectors and reads back pending, overrun and ID.

## Interface
- EVENTS_NUM, 32: number of event sources (≥2).
- CNT_W, 8: width of the coalescing event counter and of the threshold.
- TMO_W, 16: width of the coalescing timer and of the timeout.
- i_clk  in  1  clock.
- i_nrst  in  1  reset; one clock, asynchronous, active-low.
- i_events  in  EVENTS_NUM  raw event inputs, synchronous to i_clk.
- i_edge_mode  in  EVENTS_NUM  per-source capture mode: 1 = rising edge, 0 = level.
- i_mask  in  EVENTS_NUM  1 = source excluded from the IRQ bus and from coalescing.
- i_set  in  EVENTS_NUM  software set pulse per source.
- i_clear  in  EVENTS_NUM  write-1-to-clear pulse for pending and overrun.
- i_coal_thr  in  CNT_W  capture cycles needed before o_irq; 0 or 1 = immediate.
- i_coal_tmo  in  TMO_W  maximum accumulate time in cycles; 0 = no timeout.
- o_pending  out  EVENTS_NUM  sticky pending status.
- o_overrun  out  EVENTS_NUM  sticky "event captured while already pending".
- o_irq_bus  out  EVENTS_NUM  registered pending & ~mask.
- o_irq  out  1  combined, coalesced interrupt.
- o_irq_id  out  $clog2(EVENTS_NUM)  lowest set index of o_irq_bus; 0 when none.

## Operation
- Every output resets to 0. The edge-detect history and all internal counters also reset to 0.
- Capture per bit: cap = i_set | (edge_mode ? (i_events & ~prev) : i_events). prev is last cycle's i_events.
  - Because prev resets to 0, an input that is high at reset release counts as an edge.
- Pending update per bit:
  - cap sets pending.
  - Otherwise i_clear clears it.
  - If cap and i_clear coincide, capture wins.
- Overrun per bit:
  - Set when cap occurs while pending is already 1 and i_clear is low.
  - Cleared by i_clear.
  - If overrun set and clear coincide, clear wins.
- Mask:
  - Does not affect pending or overrun.
  - Masked bits drop from o_irq_bus on the next edge.
- Coalescing FSM. Definitions: ucap = |(cap & ~i_mask); act = |(pending & ~i_mask) after the update.
  - IDLE:
    - On ucap, cnt ← 1 and tmr ← 0.
    - If thr ≤ 1, go to FIRE; else go to ACCUM.
  - ACCUM:
    - Each cycle: tmr ← tmr+1 (saturating). On ucap, cnt ← cnt+1 (saturating).
    - Go to FIRE when the new cnt ≥ thr, or when tmo ≠ 0 and the new tmr == tmo.
    - If !act, go to IDLE. This check has priority over the FIRE conditions.
  - FIRE:
    - o_irq = 1.
    - When !act, go to IDLE and clear cnt and tmr.
    - New captures while in FIRE do not change the state.
- o_irq is a registered decode of state == FIRE. o_irq_id is a registered lowest-index priority encode of the next o_irq_bus.

## Timing
- Event sampled high at edge k: o_pending is visible after k, and o_irq_bus and o_irq_id after k+1.
  - With thr ≤ 1, o_irq is also high after k+1.
- Clear at edge k: pending drops after k; o_irq_bus drops after k+1.
  - If this leaves no unmasked pending bit, o_irq drops after k+1.
- Timeout: o_irq asserts tmo+1 cycles after the edge that entered ACCUM.
- Threshold: o_irq asserts one edge after the edge at which cnt reached thr.
- Changing i_coal_thr or i_coal_tmo mid-ACCUM takes effect on the next comparison.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

## Test plan
- Level event on bit 3, thr=0, mask=0 → o_pending[3]=1 after k; o_irq_bus[3]=1, o_irq=1, o_irq_id=3 after k+1. Clear bit 3 (input low) → o_irq=0 two edges later.
- Edge mode on bit 5 with input held high for 10 cycles → a single capture. Second rising edge without a clear → o_overrun[5]=1. Clear and a new edge in the same cycle → pending stays 1 and overrun becomes 0.
- thr=4, tmo=0, unmasked captures on 4 separate cycles → o_irq rises only after the 4th. Clear everything during ACCUM after 2 captures → state returns to IDLE and o_irq never asserts.
- thr=200, tmo=10, one capture → o_irq asserts exactly 11 cycles after ACCUM entry.
- Bits 7 and 2 pending with mask[2]=1 → o_irq_id=7. Unmask bit 2 → o_irq_id=2 on the next edge. Mask all bits while in FIRE → o_irq=0 and o_pending unchanged.
- Reset asserted while in FIRE with pending bits set → all outputs 0 immediately. Input high at reset release in edge mode → captured on the first edge.

Source files
------------

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: sticky per-source pending/overrun capture, masked IRQ bus,
// and one coalesced interrupt line with a lowest-index source ID.
//
// state   | meaning
// S_IDLE  | no unmasked activity being accumulated
// S_ACCUM | counting unmasked captures and elapsed cycles towards threshold/timeout
// S_FIRE  | combined interrupt asserted until no unmasked source remains pending
module uart_irq_ctrl #(
  parameter int EVENTS_NUM = 32,
  parameter int CNT_W      = 8,
  parameter int TMO_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [EVENTS_NUM-1:0]         i_events,
  input  logic [EVENTS_NUM-1:0]         i_edge_mode,
  input  logic [EVENTS_NUM-1:0]         i_mask,
  input  logic [EVENTS_NUM-1:0]         i_set,
  input  logic [EVENTS_NUM-1:0]         i_clear,
  input  logic [CNT_W-1:0]              i_coal_thr,
  input  logic [TMO_W-1:0]              i_coal_tmo,
  output logic [EVENTS_NUM-1:0]         o_pending,
  output logic [EVENTS_NUM-1:0]         o_overrun,
  output logic [EVENTS_NUM-1:0]         o_irq_bus,
  output logic                          o_irq,
  output logic [$clog2(EVENTS_NUM)-1:0] o_irq_id
);

  localparam int ID_W = $clog2(EVENTS_NUM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [EVENTS_NUM-1:0] r_prev;
  logic [EVENTS_NUM-1:0] r_pending;
  logic [EVENTS_NUM-1:0] r_overrun;
  logic [EVENTS_NUM-1:0] r_irq_bus;
  logic [ID_W-1:0]       r_irq_id;
  logic [CNT_W-1:0]      r_cnt;
  logic [TMO_W-1:0]      r_tmr;
  logic                  r_irq;

  logic [EVENTS_NUM-1:0] w_cap;
  logic [EVENTS_NUM-1:0] w_pend_nxt;
  logic [EVENTS_NUM-1:0] w_ovr_nxt;
  logic [EVENTS_NUM-1:0] w_unmasked;
  logic                  w_ucap;
  logic                  w_act;
  logic [CNT_W-1:0]      w_cnt_new;
  logic [TMO_W-1:0]      w_tmr_inc;
  logic [ID_W-1:0]       w_id;

  assign w_cap      = i_set | (i_edge_mode & i_events & ~r_prev) | (~i_edge_mode & i_events);
  // capture beats clear for pending; clear beats a new overrun
  assign w_pend_nxt = w_cap | (r_pending & ~i_clear);
  assign w_ovr_nxt  = (r_overrun | (w_cap & r_pending)) & ~i_clear;
  assign w_unmasked = r_pending & ~i_mask;
  assign w_ucap     = |(w_cap & ~i_mask);
  assign w_act      = |(w_pend_nxt & ~i_mask);

  assign w_cnt_new = !w_ucap ? r_cnt : ((r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1));
  assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + TMO_W'(1);

  always_comb begin
    w_id = '0;
    for (int i = EVENTS_NUM - 1; i >= 0; i--) begin
      if (w_unmasked[i]) w_id = ID_W'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_irq_bus <= '0;
      r_irq_id  <= '0;
    end else begin
      r_prev    <= i_events;
      r_pending <= w_pend_nxt;
      r_overrun <= w_ovr_nxt;
      r_irq_bus <= w_unmasked;
      r_irq_id  <= w_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= (r_state == S_FIRE);
      case (r_state)
        S_IDLE: begin
          if (w_ucap) begin
            r_cnt   <= CNT_W'(1);
            r_tmr   <= '0;
            r_state <= (i_coal_thr <= CNT_W'(1)) ? S_FIRE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_cnt <= w_cnt_new;
          r_tmr <= w_tmr_inc;
          if (!w_act) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
          end else if ((w_cnt_new >= i_coal_thr) ||
                       ((i_coal_tmo != '0) && (w_tmr_inc == i_coal_tmo))) begin
            r_state <= S_FIRE;
          end
        end
        S_FIRE: begin
          if (!w_act) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pending = r_pending;
  assign o_overrun = r_overrun;
  assign o_irq_bus = r_irq_bus;
  assign o_irq     = r_irq;
  assign o_irq_id  = r_irq_id;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Directed bench for uart_irq_ctrl: stimulus queues hand-computed expectations tagged
// with the clock edge they apply to; a monitor checks them just after that edge.
module tb_uart_irq_ctrl;

  localparam int N  = 32;
  localparam int CW = 8;
  localparam int TW = 16;

  localparam int F_PEND = 0;
  localparam int F_OVR  = 1;
  localparam int F_BUS  = 2;
  localparam int F_IRQ  = 3;
  localparam int F_ID   = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic [N-1:0]  ev, em, msk, st, clr;
  logic [CW-1:0] thr;
  logic [TW-1:0] tmo;
  logic [N-1:0]  o_pending, o_overrun, o_irq_bus;
  logic          o_irq;
  logic [4:0]    o_irq_id;

  uart_irq_ctrl #(.EVENTS_NUM(N), .CNT_W(CW), .TMO_W(TW)) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_events   (ev),
    .i_edge_mode(em),
    .i_mask     (msk),
    .i_set      (st),
    .i_clear    (clr),
    .i_coal_thr (thr),
    .i_coal_tmo (tmo),
    .o_pending  (o_pending),
    .o_overrun  (o_overrun),
    .o_irq_bus  (o_irq_bus),
    .o_irq      (o_irq),
    .o_irq_id   (o_irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] m;
    logic [31:0] e;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_edge = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic check(input int f, input logic [31:0] m, input logic [31:0] e, input string nm);
    logic [31:0] a;
    case (f)
      F_PEND:  a = o_pending;
      F_OVR:   a = o_overrun;
      F_BUS:   a = o_irq_bus;
      F_IRQ:   a = {31'b0, o_irq};
      default: a = {27'b0, o_irq_id};
    endcase
    n_vec++;
    if ((a & m) !== e) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (mask %h) at edge %0d", nm, a & m, e, m, n_edge);
    end
  endtask

  function automatic void push_exp(input int d, input int f, input logic [31:0] m,
                                   input logic [31:0] e, input string nm);
    exp_t x;
    x.cyc  = n_edge + d;
    x.fld  = f;
    x.m    = m;
    x.e    = e;
    x.name = nm;
    q.push_back(x);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // monitor: checks every expectation due at this edge, just after it settles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_edge++;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == n_edge) begin
          check(q[i].fld, q[i].m, q[i].e, q[i].name);
          q.delete(i);
        end else if (q[i].cyc < n_edge) begin
          n_vec++;
          n_err++;
          $display("FAIL stale_%s: got unchecked, want check at edge %0d", q[i].name, q[i].cyc);
          q.delete(i);
        end
      end
    end
  end

  initial begin
    ev = '0; em = '0; msk = '0; st = '0; clr = '0; thr = '0; tmo = '0; nrst = 1'b0;
    tick();
    push_exp(1, F_PEND, '1, 0, "rst_pend");
    push_exp(1, F_OVR,  '1, 0, "rst_ovr");
    push_exp(1, F_BUS,  '1, 0, "rst_bus");
    push_exp(1, F_IRQ,  1,  0, "rst_irq");
    push_exp(1, F_ID,   '1, 0, "rst_id");
    tick();
    nrst = 1'b1;
    tick();

    // level event on bit 3, immediate fire, then clear
    ev[3] = 1'b1;
    push_exp(1, F_PEND, 32'h8, 32'h8, "t1_pend");
    push_exp(1, F_IRQ,  1, 0, "t1_irq_latency");
    push_exp(2, F_BUS,  '1, 32'h8, "t1_bus");
    push_exp(2, F_IRQ,  1, 1, "t1_irq");
    push_exp(2, F_ID,   '1, 3, "t1_id");
    tick();
    ev[3] = 1'b0; clr[3] = 1'b1;
    push_exp(1, F_PEND, 32'h8, 0, "t1_pend_clr");
    push_exp(2, F_BUS,  '1, 0, "t1_bus_clr");
    push_exp(2, F_IRQ,  1, 0, "t1_irq_drop");
    push_exp(2, F_ID,   '1, 0, "t1_id_clr");
    tick();
    clr = '0;
    tick(); tick();

    // edge mode on bit 5: one capture over a long high, overrun, clear vs capture
    em[5] = 1'b1; ev[5] = 1'b1;
    push_exp(1, F_PEND, 32'h20, 32'h20, "t2_cap");
    repeat (9) tick();
    push_exp(1, F_OVR,  32'h20, 0, "t2_hold_ovr");
    push_exp(1, F_PEND, 32'h20, 32'h20, "t2_hold_pend");
    tick();
    ev[5] = 1'b0;
    tick();
    ev[5] = 1'b1;
    push_exp(1, F_OVR, 32'h20, 32'h20, "t2_ovr");
    tick();
    ev[5] = 1'b0;
    tick();
    ev[5] = 1'b1; clr[5] = 1'b1;
    push_exp(1, F_PEND, 32'h20, 32'h20, "t2_capwin_pend");
    push_exp(1, F_OVR,  32'h20, 0, "t2_clrwin_ovr");
    tick();
    ev[5] = 1'b0; clr[5] = 1'b0;
    tick();
    clr[5] = 1'b1;
    tick();
    clr = '0; em = '0;
    tick(); tick();

    // threshold 4: fires only after the 4th capture
    thr = 8'd4;
    st[0] = 1'b1; tick(); st = '0; tick();
    st[1] = 1'b1; tick(); st = '0; tick();
    st[2] = 1'b1;
    push_exp(2, F_IRQ, 1, 0, "t3_irq_3caps");
    tick(); st = '0; tick();
    st[3] = 1'b1;
    push_exp(1, F_IRQ,  1, 0, "t3_irq_4th_edge");
    push_exp(1, F_PEND, '1, 32'hF, "t3_pend");
    push_exp(2, F_IRQ,  1, 1, "t3_irq_fire");
    tick(); st = '0; tick();
    clr = '1; tick(); clr = '0; tick(); tick();

    // clear during accumulation returns to idle: two more captures must not fire
    st[4] = 1'b1; tick(); st = '0; tick();
    st[6] = 1'b1; tick(); st = '0;
    clr = '1;
    push_exp(1, F_PEND, '1, 0, "t3b_pend_clr");
    push_exp(2, F_IRQ,  1, 0, "t3b_irq_clr");
    tick(); clr = '0; tick();
    st[8] = 1'b1; tick(); st = '0; tick();
    st[10] = 1'b1;
    push_exp(1, F_IRQ, 1, 0, "t3b_irq_a");
    push_exp(2, F_IRQ, 1, 0, "t3b_irq_b");
    push_exp(3, F_IRQ, 1, 0, "t3b_irq_c");
    tick(); st = '0; tick(); tick();
    clr = '1; tick(); clr = '0; thr = '0; tick(); tick();

    // timeout 10 with unreachable threshold
    thr = 8'd200; tmo = 16'd10;
    st[1] = 1'b1;
    push_exp(11, F_IRQ, 1, 0, "t4_irq_early");
    push_exp(12, F_IRQ, 1, 1, "t4_irq_tmo");
    tick(); st = '0;
    repeat (12) tick();
    clr = '1; tick(); clr = '0; thr = '0; tmo = '0; tick(); tick();

    // masking and ID priority
    msk[2] = 1'b1; st[7] = 1'b1; st[2] = 1'b1;
    push_exp(1, F_PEND, '1, 32'h84, "t5_pend");
    push_exp(2, F_ID,   '1, 7, "t5_id_masked");
    push_exp(2, F_BUS,  '1, 32'h80, "t5_bus_masked");
    tick(); st = '0; tick();
    msk = '0;
    push_exp(1, F_ID,  '1, 2, "t5_id_unmask");
    push_exp(1, F_BUS, '1, 32'h84, "t5_bus_unmask");
    tick(); tick();
    msk = '1;
    push_exp(1, F_IRQ,  1, 1, "t5_irq_on");
    push_exp(2, F_IRQ,  1, 0, "t5_irq_maskall");
    push_exp(2, F_PEND, '1, 32'h84, "t5_pend_kept");
    push_exp(2, F_BUS,  '1, 0, "t5_bus_maskall");
    tick(); tick(); tick();
    msk = '0; tick();
    clr = '1; tick(); clr = '0; tick(); tick();

    // async reset while firing, then an input high at reset release in edge mode
    st[9] = 1'b1; tick(); st = '0; tick();
    push_exp(1, F_IRQ, 1, 1, "t6_irq_pre");
    tick();
    nrst = 1'b0;
    #1;
    check(F_PEND, '1, 0, "t6_rst_pend");
    check(F_OVR,  '1, 0, "t6_rst_ovr");
    check(F_BUS,  '1, 0, "t6_rst_bus");
    check(F_IRQ,  1,  0, "t6_rst_irq");
    check(F_ID,   '1, 0, "t6_rst_id");
    em[12] = 1'b1; ev[12] = 1'b1;
    tick(); tick();
    nrst = 1'b1;
    push_exp(1, F_PEND, '1, 32'h1000, "t6_edge_at_release");
    push_exp(2, F_OVR,  '1, 0, "t6_no_ovr");
    tick();
    ev = '0;
    repeat (3) tick();

    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL leftover: got %0d unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
